pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register carrying a control and a data bundle.
// Optional two-entry skid mode keeps in_ready registered to break long ready chains.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_reg;
  logic              valid_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic              accept;
  logic              pop;

  assign accept    = in_valid & in_ready;
  assign pop       = valid_reg & out_ready;
  assign out_valid = valid_reg;
  assign out_ctrl  = main_ctrl_reg;
  assign out_data  = main_data_reg;
  assign occupancy = state_reg;

  generate
    if (SKID == 0) begin : g_single
      assign in_ready = ~valid_reg | out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg     <= ST_EMPTY;
          valid_reg     <= 1'b0;
          main_ctrl_reg <= '0;
          main_data_reg <= '0;
        end else if (flush) begin
          // Data is left in place; only control is zeroed so the bubble is harmless.
          state_reg     <= ST_EMPTY;
          valid_reg     <= 1'b0;
          main_ctrl_reg <= '0;
        end else if (accept) begin
          state_reg     <= ST_FULL;
          valid_reg     <= 1'b1;
          main_ctrl_reg <= in_ctrl;
          main_data_reg <= in_data;
        end else if (pop) begin
          state_reg     <= ST_EMPTY;
          valid_reg     <= 1'b0;
          main_ctrl_reg <= '0;
        end
      end
    end else begin : g_skid
      logic              in_ready_reg;
      logic [CTRL_W-1:0] skid_ctrl_reg;
      logic [DATA_W-1:0] skid_data_reg;

      assign in_ready = in_ready_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg     <= ST_EMPTY;
          valid_reg     <= 1'b0;
          in_ready_reg  <= 1'b1;
          main_ctrl_reg <= '0;
          main_data_reg <= '0;
          skid_ctrl_reg <= '0;
          skid_data_reg <= '0;
        end else if (flush) begin
          state_reg     <= ST_EMPTY;
          valid_reg     <= 1'b0;
          in_ready_reg  <= 1'b1;
          main_ctrl_reg <= '0;
        end else begin
          case (state_reg)
            ST_EMPTY: begin
              if (accept) begin
                state_reg     <= ST_FULL;
                valid_reg     <= 1'b1;
                main_ctrl_reg <= in_ctrl;
                main_data_reg <= in_data;
              end
            end
            ST_FULL: begin
              if (accept && pop) begin
                main_ctrl_reg <= in_ctrl;
                main_data_reg <= in_data;
              end else if (accept) begin
                // Downstream stalled: park the newcomer and close the input.
                state_reg     <= ST_SKID;
                in_ready_reg  <= 1'b0;
                skid_ctrl_reg <= in_ctrl;
                skid_data_reg <= in_data;
              end else if (pop) begin
                state_reg     <= ST_EMPTY;
                valid_reg     <= 1'b0;
                main_ctrl_reg <= '0;
              end
            end
            ST_SKID: begin
              if (pop) begin
                state_reg     <= ST_FULL;
                in_ready_reg  <= 1'b1;
                main_ctrl_reg <= skid_ctrl_reg;
                main_data_reg <= skid_data_reg;
              end
            end
            default: begin
              state_reg     <= ST_EMPTY;
              valid_reg     <= 1'b0;
              in_ready_reg  <= 1'b1;
              main_ctrl_reg <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule
